// File: rtl/uart_cfg_sequencer.sv
// Power-up UART configurator: writes the divisor/LCR/FCR/IER sequence over a
// Wishbone-style port, then hands the UART port to the host as a pass-through.
module uart_cfg_sequencer #(
  parameter logic [15:0] DIVISOR        = 16'h0034,
  parameter logic [7:0]  LCR_VALUE      = 8'h03,
  parameter logic [7:0]  FCR_VALUE      = 8'hC7,
  parameter logic [7:0]  IER_VALUE      = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 7
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic        Start_i,
  input  logic [3:0]  Host_ADR_i,
  input  logic        Host_CYC_i,
  input  logic        Host_WE_i,
  input  logic        Host_STB_i,
  input  logic [7:0]  Host_DAT_i,
  output logic [15:0] Host_DAT_o,
  output logic        Host_ACK_o,
  output logic [3:0]  UART_ADR_o,
  output logic        UART_CYC_o,
  output logic        UART_WE_o,
  output logic        UART_STB_o,
  output logic [7:0]  UART_DAT_o,
  input  logic [15:0] UART_DAT_i,
  input  logic        UART_ACK_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic        Err_o
);

  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_STEP = 3'd5;

  typedef enum logic [1:0] {
    S_DRIVE,
    S_GAP,
    S_READY,
    S_PEND
  } state_t;

  state_t           r_state;
  logic [2:0]       r_step;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_done;
  logic             r_err;

  logic [3:0]       w_step_adr;
  logic [7:0]       w_step_dat;
  logic             w_tmo_hit;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_step_adr = 4'd0;
    w_step_dat = 8'h00;
    case (r_step)
      3'd0:    begin w_step_adr = 4'd3; w_step_dat = 8'h80;                   end
      3'd1:    begin w_step_adr = 4'd0; w_step_dat = DIVISOR[7:0];            end
      3'd2:    begin w_step_adr = 4'd1; w_step_dat = DIVISOR[15:8];           end
      3'd3:    begin w_step_adr = 4'd3; w_step_dat = {1'b0, LCR_VALUE[6:0]};  end
      3'd4:    begin w_step_adr = 4'd2; w_step_dat = FCR_VALUE;               end
      3'd5:    begin w_step_adr = 4'd1; w_step_dat = IER_VALUE;               end
      default: ;
    endcase
  end

  // The counter holds the number of un-acked DRIVE cycles already elapsed, so
  // the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      r_state   <= S_DRIVE;
      r_step    <= 3'd0;
      r_tmo_cnt <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_DRIVE: begin
          if (UART_ACK_i) begin
            r_tmo_cnt <= '0;
            if (r_step == LAST_STEP) begin
              r_done  <= 1'b1;
              r_state <= S_READY;
            end else begin
              r_step  <= r_step + 3'd1;
              r_state <= S_GAP;
            end
          end else if (w_tmo_hit) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b1;
            r_state   <= S_READY;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end
        S_GAP: begin
          r_tmo_cnt <= '0;
          r_state   <= S_DRIVE;
        end
        S_READY: begin
          if (Start_i) begin
            if (Host_CYC_i) begin
              r_state <= S_PEND;
            end else begin
              r_step    <= 3'd0;
              r_tmo_cnt <= '0;
              r_done    <= 1'b0;
              r_err     <= 1'b0;
              r_state   <= S_DRIVE;
            end
          end
        end
        S_PEND: begin
          if (!Host_CYC_i) begin
            r_step    <= 3'd0;
            r_tmo_cnt <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_state   <= S_DRIVE;
          end
        end
        default: r_state <= S_DRIVE;
      endcase
    end
  end

  // Bus outputs are decoded from state rather than registered because the
  // host path must be a same-cycle pass-through; reset masks them at once.
  always_comb begin
    UART_ADR_o = 4'd0;
    UART_CYC_o = 1'b0;
    UART_WE_o  = 1'b0;
    UART_STB_o = 1'b0;
    UART_DAT_o = 8'h00;
    Host_DAT_o = 16'h0000;
    Host_ACK_o = 1'b0;
    Busy_o     = 1'b1;
    Done_o     = 1'b0;
    Err_o      = 1'b0;
    if (!WBs_RST_i) begin
      Done_o = r_done;
      Err_o  = r_err;
      case (r_state)
        S_DRIVE: begin
          UART_ADR_o = w_step_adr;
          UART_CYC_o = 1'b1;
          UART_WE_o  = 1'b1;
          UART_STB_o = 1'b1;
          UART_DAT_o = w_step_dat;
        end
        S_READY, S_PEND: begin
          UART_ADR_o = Host_ADR_i;
          UART_CYC_o = Host_CYC_i;
          UART_WE_o  = Host_WE_i;
          UART_STB_o = Host_STB_i;
          UART_DAT_o = Host_DAT_i;
          Host_DAT_o = UART_DAT_i;
          Host_ACK_o = UART_ACK_i;
          Busy_o     = (r_state == S_PEND);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_cfg_sequencer.md
UART_CFG_SEQUENCER -- requirements
Module: uart_cfg_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; clock and reset ports are named WBs_CLK_i and WBs_RST_i.
REQ-002 Parameters SHALL be (name, default, meaning):
- DIVISOR, 16'h0034, baud divisor.
- LCR_VALUE, 8'h03, final LCR value.
- FCR_VALUE, 8'hC7, FIFO control value.
- IER_VALUE, 8'h00, interrupt enable value.
- TIMEOUT_CYCLES, 7, maximum cycles waiting for an ACK.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- WBs_CLK_i, in, 1, clock.
- WBs_RST_i, in, 1, synchronous reset.
- Start_i, in, 1, re-initialisation request pulse.
- Host_ADR_i, in, 4, host word address.
- Host_CYC_i, in, 1, host cycle.
- Host_WE_i, in, 1, host write enable.
- Host_STB_i, in, 1, host strobe.
- Host_DAT_i, in, 8, host write data.
- Host_DAT_o, out, 16, read data to host.
- Host_ACK_o, out, 1, acknowledge to host.
- UART_ADR_o, out, 4, UART word address.
- UART_CYC_o, out, 1, UART cycle.
- UART_WE_o, out, 1, UART write enable.
- UART_STB_o, out, 1, UART strobe.
- UART_DAT_o, out, 8, UART write data.
- UART_DAT_i, in, 16, UART read data.
- UART_ACK_i, in, 1, UART acknowledge.
- Busy_o, out, 1, sequence in progress.
- Done_o, out, 1, last sequence completed.
- Err_o, out, 1, last sequence timed out.

Function
REQ-004 The block SHALL have exactly four states:
- DRIVE: sequencer owns the UART port and drives one write.
- GAP: one cycle between sequencer writes.
- READY: host pass-through.
- PEND: host pass-through with a restart pending.
REQ-005 The write sequence SHALL consist of six steps, each given as (UART_ADR_o, UART_DAT_o):
- 0: (3, 8'h80)
- 1: (0, DIVISOR[7:0])
- 2: (1, DIVISOR[15:8])
- 3: (3, {1'b0, LCR_VALUE[6:0]})
- 4: (2, FCR_VALUE)
- 5: (1, IER_VALUE)
REQ-006 In DRIVE, UART_CYC_o, UART_STB_o and UART_WE_o SHALL be 1, and address and data SHALL come from the current step.
REQ-007 When UART_ACK_i is sampled 1 in DRIVE:
- if step < 5: increment the step and go to GAP;
- if step == 5: set Done_o = 1 and go to READY.
REQ-008 GAP SHALL last exactly one cycle with UART_CYC_o = UART_STB_o = 0, then return to DRIVE.
REQ-009 A timeout counter (width clog2(TIMEOUT_CYCLES+1)) SHALL clear on entry to DRIVE and increment each DRIVE cycle without an ACK.
REQ-010 When the timeout counter reaches TIMEOUT_CYCLES without an ACK, the block SHALL:
- set Err_o = 1 and leave Done_o = 0;
- drop the cycle and go to READY, skipping the remaining steps.
REQ-011 In DRIVE and GAP, Host_ACK_o SHALL be 0 and Host_DAT_o SHALL be 16'h0, so host cycles stall.
REQ-012 In READY and PEND, the UART_* outputs SHALL equal the corresponding Host_* inputs combinationally, with Host_DAT_o = UART_DAT_i and Host_ACK_o = UART_ACK_i.
REQ-013 Start_i sampled 1 in READY with Host_CYC_i = 0 SHALL clear Done_o, Err_o and the step counter and enter DRIVE in the next cycle.
REQ-014 Start_i sampled 1 in READY with Host_CYC_i = 1 SHALL enter PEND.
- PEND SHALL enter DRIVE (clearing Done_o, Err_o and the step counter) on the cycle after Host_CYC_i is sampled 0.
- Start_i in PEND SHALL be ignored.
REQ-015 Start_i in DRIVE or GAP SHALL be ignored.
REQ-016 Busy_o SHALL be 1 exactly in DRIVE, GAP and PEND.
REQ-017 Done_o and Err_o SHALL never both be 1 at the same time.
REQ-018 If UART_ACK_i and the timeout condition occur in the same cycle, the ACK SHALL win and no error is flagged.

Reset
REQ-019 While WBs_RST_i is 1, the block SHALL hold:
- state DRIVE, step 0, timeout counter 0;
- UART_CYC_o, UART_STB_o, UART_WE_o = 0; UART_ADR_o = 0; UART_DAT_o = 0;
- Host_ACK_o = 0; Host_DAT_o = 0;
- Busy_o = 1; Done_o = 0; Err_o = 0.
REQ-020 In the first cycle after WBs_RST_i falls, UART_CYC_o SHALL be 1 with step 0 presented, so the sequence starts automatically.
REQ-021 Reset asserted at any point, including mid-sequence or during a host pass-through cycle, SHALL abandon the current operation and restart the sequence from step 0 after release.

Verification
REQ-022 Default parameters, UART acknowledges each write on the 2nd cycle of the write:
- the UART SHALL observe writes (3,80), (0,34), (1,00), (3,03), (2,C7), (1,00) in order, each separated by one idle cycle;
- Done_o SHALL rise the cycle after the last ACK.
REQ-023 UART never acknowledges step 2:
- Err_o SHALL be 1 exactly 7 DRIVE cycles into step 2;
- steps 3–5 SHALL NOT be issued;
- READY pass-through SHALL work afterwards.
REQ-024 Host read of address 5 during the sequence:
- Host_ACK_o SHALL stay 0 until READY;
- the read SHALL then complete with Host_DAT_o equal to UART_DAT_i.
REQ-025 Start_i pulsed while a host cycle is active in READY:
- the host cycle SHALL complete;
- the block SHALL enter DRIVE one cycle after Host_CYC_i falls;
- the full six writes SHALL repeat.
REQ-026 WBs_RST_i asserted during step 3:
- all UART strobes SHALL be 0 while reset is held;
- after release the sequence SHALL restart at (3,80);
- Done_o SHALL be 0 until the sequence completes.
